// File: rtl/pipelined_tree_multiplier.sv
// Purpose : WIDTH x WIDTH multiplier, unsigned or Baugh-Wooley signed per transaction, with a sideband tag.
// Latency : 3 register stages (capture, carry-save reduce, carry-propagate resolve); 1 transaction/cycle.
// Backpr. : whole pipeline holds when out_valid & !out_ready; in_ready = !out_valid | out_ready.
// Ports   : clk/rst (sync, active-high); in_valid/in_ready/in_x/in_y/in_signed/in_tag operand side;
//           out_valid/out_ready/out_p/out_tag result side.
module pipelined_tree_multiplier #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int PW = 2 * WIDTH;
  // Baugh-Wooley correction constant: ones at bit WIDTH and bit 2*WIDTH-1.
  localparam logic [PW-1:0] BW_K = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

  // S1: captured operands
  logic               r_s1_vld;
  logic [WIDTH-1:0]   r_s1_x;
  logic [WIDTH-1:0]   r_s1_y;
  logic               r_s1_sgn;
  logic [TAG_W-1:0]   r_s1_tag;
  // S2: carry-save rows
  logic               r_s2_vld;
  logic [PW-1:0]      r_s2_sum;
  logic [PW-1:0]      r_s2_cry;
  logic [TAG_W-1:0]   r_s2_tag;
  // S3: resolved product
  logic               r_s3_vld;
  logic [PW-1:0]      r_s3_p;
  logic [TAG_W-1:0]   r_s3_tag;

  logic               w_adv;
  logic [WIDTH-1:0]   w_pp  [WIDTH];     // w_pp[i][j] = x[j] & y[i], weight 2^(i+j)
  logic [PW-1:0]      w_row [WIDTH+1];   // aligned rows; last row is the signed-mode constant
  logic [PW-1:0]      w_s   [WIDTH+2];   // running carry-save sum
  logic [PW-1:0]      w_c   [WIDTH+2];   // running carry-save carry

  // Every stage moves together, so one enable covers the whole pipe.
  assign w_adv    = !r_s3_vld || out_ready;
  assign in_ready = w_adv;

  // Partial-product matrix. In signed mode the MSB row and MSB column are
  // inverted, except the MSB x MSB term which is inverted twice (i.e. kept).
  for (genvar i = 0; i < WIDTH; i++) begin : g_row
    for (genvar j = 0; j < WIDTH; j++) begin : g_col
      localparam logic INV = ((i == WIDTH - 1) != (j == WIDTH - 1));
      assign w_pp[i][j] = (r_s1_x[j] & r_s1_y[i]) ^ (r_s1_sgn & INV);
    end
    assign w_row[i] = PW'(w_pp[i]) << i;
  end
  assign w_row[WIDTH] = r_s1_sgn ? BW_K : '0;

  // Chain of full-adder (3:2) compressors folding each row into the
  // sum/carry pair. Carries out of the top bit are dropped by the shift,
  // which is exactly the modulo-2^(2*WIDTH) wrap the product needs.
  assign w_s[0] = '0;
  assign w_c[0] = '0;
  for (genvar k = 0; k <= WIDTH; k++) begin : g_csa
    assign w_s[k+1] = w_s[k] ^ w_c[k] ^ w_row[k];
    assign w_c[k+1] = ((w_s[k] & w_c[k]) | (w_s[k] & w_row[k]) | (w_c[k] & w_row[k])) << 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_s1_x   <= '0;
      r_s1_y   <= '0;
      r_s1_sgn <= 1'b0;
      r_s1_tag <= '0;
      r_s2_vld <= 1'b0;
      r_s2_sum <= '0;
      r_s2_cry <= '0;
      r_s2_tag <= '0;
      r_s3_vld <= 1'b0;
      r_s3_p   <= '0;
      r_s3_tag <= '0;
    end else if (w_adv) begin
      // S1 loads in_valid directly: no input means a bubble enters.
      r_s1_vld <= in_valid;
      r_s1_x   <= in_x;
      r_s1_y   <= in_y;
      r_s1_sgn <= in_signed;
      r_s1_tag <= in_tag;
      r_s2_vld <= r_s1_vld;
      r_s2_sum <= w_s[WIDTH+1];
      r_s2_cry <= w_c[WIDTH+1];
      r_s2_tag <= r_s1_tag;
      r_s3_vld <= r_s2_vld;
      r_s3_p   <= r_s2_sum + r_s2_cry;
      r_s3_tag <= r_s2_tag;
    end
  end

  assign out_valid = r_s3_vld;
  assign out_p     = r_s3_p;
  assign out_tag   = r_s3_tag;

endmodule

// File: tb/tb_pipelined_tree_multiplier.sv
// Purpose : self-checking bench for pipelined_tree_multiplier at WIDTH=4 (ua) and WIDTH=8 (ub).
// Latency : expects results 3 edges after the transfer edge's predecessor drive cycle, one per cycle when streaming.
// Backpr. : exercises out_ready stalls, mid-flight reset and scoreboard-ordered draining.
module tb_pipelined_tree_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=4 instance signals
  logic       a_in_valid, a_in_ready, a_in_signed, a_out_valid, a_out_ready;
  logic [3:0] a_x, a_y, a_tag_i, a_tag_o;
  logic [7:0] a_p;
  // WIDTH=8 instance signals
  logic        b_in_valid, b_in_ready, b_in_signed, b_out_valid, b_out_ready;
  logic [7:0]  b_x, b_y;
  logic [3:0]  b_tag_i, b_tag_o;
  logic [15:0] b_p;

  pipelined_tree_multiplier #(.WIDTH(4), .TAG_W(4)) ua (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_x(a_x), .in_y(a_y),
    .in_signed(a_in_signed), .in_tag(a_tag_i),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_p(a_p), .out_tag(a_tag_o)
  );

  pipelined_tree_multiplier #(.WIDTH(8), .TAG_W(4)) ub (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_x(b_x), .in_y(b_y),
    .in_signed(b_in_signed), .in_tag(b_tag_i),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_p(b_p), .out_tag(b_tag_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_a = 0;
  int done_b = 0;

  logic [11:0] qa[$];      // {tag, product} expected from ua
  logic [19:0] qb[$];      // {tag, product} expected from ub
  int          cl_b[$];    // cycle numbers of ub completions
  logic [11:0] ea;
  logic [19:0] eb;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model for WIDTH=8: widen to int with the right extension.
  function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic s);
    int a, b;
    a = s ? int'($signed(x)) : int'(x);
    b = s ? int'($signed(y)) : int'(y);
    return 16'(a * b);
  endfunction

  // Scoreboard monitors: a completion is out_valid & out_ready seen mid-cycle.
  always @(negedge clk) begin
    if (!rst && a_out_valid) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_stale: got p=%h tag=%h with nothing outstanding", a_p, a_tag_o);
      end else if (a_out_ready) begin
        ea = qa.pop_front();
        checks++; done_a++;
        if ({a_tag_o, a_p} !== ea) begin
          errors++;
          $display("FAIL a_result: got tag=%h p=%h, want tag=%h p=%h", a_tag_o, a_p, ea[11:8], ea[7:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_out_valid) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_stale: got p=%h tag=%h with nothing outstanding", b_p, b_tag_o);
      end else if (b_out_ready) begin
        eb = qb.pop_front();
        checks++; done_b++;
        cl_b.push_back(cyc);
        if ({b_tag_o, b_p} !== eb) begin
          errors++;
          $display("FAIL b_result: got tag=%h p=%h, want tag=%h p=%h", b_tag_o, b_p, eb[19:16], eb[15:0]);
        end
      end
    end
  end

  // Present one transaction and hold it until accepted; returns just after the transfer edge.
  task automatic send_a(input logic [3:0] x, input logic [3:0] y, input logic s,
                        input logic [3:0] tag, input logic [7:0] exp);
    a_in_valid = 1'b1; a_x = x; a_y = y; a_in_signed = s; a_tag_i = tag;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (a_in_ready) begin
        qa.push_back({tag, exp});
        @(posedge clk); #1;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL a_accept_timeout: in_ready=%b want 1", a_in_ready);
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] x, input logic [7:0] y, input logic s,
                        input logic [3:0] tag, input logic [15:0] exp);
    b_in_valid = 1'b1; b_x = x; b_y = y; b_in_signed = s; b_tag_i = tag;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (b_in_ready) begin
        qb.push_back({tag, exp});
        @(posedge clk); #1;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL b_accept_timeout: in_ready=%b want 1", b_in_ready);
    b_in_valid = 1'b0;
  endtask

  task automatic drain_a(input string nm);
    int n;
    n = 0;
    a_in_valid = 1'b0;
    while (qa.size() != 0 && n < 200) begin @(posedge clk); n++; end
    #1;
    checks++;
    if (qa.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d results outstanding, want 0", nm, qa.size());
    end
  endtask

  task automatic drain_b(input string nm);
    int n;
    n = 0;
    b_in_valid = 1'b0;
    while (qb.size() != 0 && n < 200) begin @(posedge clk); n++; end
    #1;
    checks++;
    if (qb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d results outstanding, want 0", nm, qb.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_out_valid, a_p, a_tag_o} !== 13'h0) begin
      errors++;
      $display("FAIL reset_a: valid=%b p=%h tag=%h, want 0/00/0", a_out_valid, a_p, a_tag_o);
    end
    checks++;
    if ({b_out_valid, b_p, b_tag_o} !== 21'h0) begin
      errors++;
      $display("FAIL reset_b: valid=%b p=%h tag=%h, want 0/0000/0", b_out_valid, b_p, b_tag_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_in_ready, b_in_ready} !== 2'b11) begin
      errors++;
      $display("FAIL reset_in_ready: a=%b b=%b, want 1/1", a_in_ready, b_in_ready);
    end
  endtask

  // Unsigned WIDTH=4, including the first-result latency.
  task automatic test_unsigned4();
    @(posedge clk); #1;          // edge N: operands driven in the following cycle
    a_in_valid = 1'b1; a_x = 4'hF; a_y = 4'hF; a_in_signed = 1'b0; a_tag_i = 4'h3;
    qa.push_back({4'h3, 8'hE1});
    @(posedge clk); #1;          // edge N+1: transfer
    a_in_valid = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      checks++;
      if (a_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL latency_early_%0d: out_valid=%b want 0", k, a_out_valid);
      end
    end
    @(negedge clk);              // after edge N+3
    checks++;
    if ({a_out_valid, a_p} !== {1'b1, 8'hE1}) begin
      errors++;
      $display("FAIL latency_n3: valid=%b p=%h, want 1/e1", a_out_valid, a_p);
    end
    @(posedge clk); #1;
    send_a(4'h0, 4'h9, 1'b0, 4'h4, 8'h00);
    drain_a("unsigned4");
  endtask

  task automatic test_signed4();
    send_a(4'h8, 4'h8, 1'b1, 4'h5, 8'h40);
    send_a(4'hF, 4'h7, 1'b1, 4'h6, 8'hF9);
    send_a(4'h7, 4'h8, 1'b1, 4'h7, 8'hC8);
    send_a(4'hF, 4'h7, 1'b0, 4'h8, 8'h69);   // same bits unsigned: 15*7=105
    drain_a("signed4");
  endtask

  task automatic test_back_to_back();
    logic [7:0] x, y;
    logic s;
    int d0;
    d0 = done_b;
    cl_b.delete();
    for (int i = 0; i < 64; i++) begin
      x = 8'($urandom); y = 8'($urandom); s = 1'($urandom_range(0, 1));
      send_b(x, y, s, 4'(i), ref8(x, y, s));
    end
    drain_b("stream");
    checks++;
    if (done_b - d0 != 64 || cl_b.size() != 64) begin
      errors++;
      $display("FAIL stream_count: got %0d results, want 64", done_b - d0);
    end else if (cl_b[63] - cl_b[0] != 63) begin
      errors++;
      $display("FAIL stream_rate: span %0d cycles, want 63", cl_b[63] - cl_b[0]);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] hp;
    logic [3:0]  ht;
    int d0, n;
    b_out_ready = 1'b0;
    d0 = done_b;
    send_b(8'd10, 8'd20, 1'b0, 4'h5, 16'd200);
    send_b(8'hFD, 8'h07, 1'b1, 4'h6, 16'hFFEB);  // -3 * 7 = -21
    send_b(8'h81, 8'h02, 1'b0, 4'h7, 16'h0102);
    b_in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!b_out_valid && n < 20) begin @(negedge clk); n++; end
    hp = b_p; ht = b_tag_o;
    checks++;
    if (b_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_valid_timeout: out_valid=%b want 1", b_out_valid);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (b_in_ready !== 1'b0 || b_p !== hp || b_tag_o !== ht || b_p !== 16'd200) begin
        errors++;
        $display("FAIL bp_hold_%0d: in_ready=%b p=%h tag=%h, want 0 p=%h(00c8) tag=%h",
                 k, b_in_ready, b_p, b_tag_o, hp, ht);
      end
    end
    @(posedge clk); #1;
    b_out_ready = 1'b1;
    drain_b("bp");
    checks++;
    if (done_b - d0 != 3) begin
      errors++;
      $display("FAIL bp_count: got %0d results, want 3", done_b - d0);
    end
  endtask

  task automatic test_reset_midflight();
    int d0;
    b_out_ready = 1'b0;
    send_b(8'd9, 8'd9, 1'b0, 4'h1, 16'd81);
    send_b(8'd7, 8'd6, 1'b0, 4'h2, 16'd42);
    send_b(8'd2, 8'd2, 1'b1, 4'h3, 16'd4);
    b_in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    qb.delete();
    b_out_ready = 1'b1;
    d0 = done_b;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL rst_flush_%0d: out_valid=%b in_ready=%b, want 0/1", k, b_out_valid, b_in_ready);
      end
    end
    @(posedge clk); #1;
    send_b(8'd3, 8'd5, 1'b0, 4'hA, 16'd15);
    drain_b("rst_mid");
    checks++;
    if (done_b - d0 != 1) begin
      errors++;
      $display("FAIL rst_mid_count: got %0d results, want 1", done_b - d0);
    end
  endtask

  task automatic test_corners8();
    send_b(8'h80, 8'h80, 1'b1, 4'hB, 16'h4000);
    send_b(8'hFF, 8'hFF, 1'b0, 4'hC, 16'hFE01);
    send_b(8'hFF, 8'hFF, 1'b1, 4'hD, 16'h0001);
    send_b(8'h80, 8'h7F, 1'b1, 4'hE, 16'hC080);
    drain_b("corners");
  endtask

  initial begin
    a_in_valid = 1'b0; a_x = '0; a_y = '0; a_in_signed = 1'b0; a_tag_i = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_x = '0; b_y = '0; b_in_signed = 1'b0; b_tag_i = '0; b_out_ready = 1'b1;
    test_reset();
    test_unsigned4();
    test_signed4();
    test_corners8();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
